// File: rtl/cache_pkg.sv
// cache_pkg -- shared geometry, address layout and FSM state type for the
// two-way cache fill controller (cache_fill_ctrl, cache_lru).
// Address layout: tag[15:10], index[9:4], offset[3:0] (byte offset, word = offset[3:1]).
package cache_pkg;

   localparam int unsigned NUM_SETS       = 64;
   localparam int unsigned BLOCK_WORDS    = 8;
   localparam int unsigned ADDR_W         = 16;
   localparam int unsigned DATA_W         = 16;
   localparam int unsigned TAG_W          = 6;
   localparam int unsigned INDEX_W        = 6;
   localparam int unsigned OFFSET_W       = 4;
   localparam int unsigned WORD_W         = 3;
   localparam int unsigned CNT_W          = WORD_W + 1;
   localparam int unsigned META_W         = 8;
   localparam int unsigned META_VALID_BIT = 7;

   typedef struct packed {
      logic [TAG_W-1:0]    tag;
      logic [INDEX_W-1:0]  index;
      logic [OFFSET_W-1:0] offset;
   } cacheAddr_t;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      FILL = 2'd1,
      META = 2'd2
   } fillState_t;

endpackage

// File: rtl/cache_lru.sv
// cache_lru -- per-set LRU bit table (NUM_SETS bits).
// A bit value of 1 names way1 as least recently used, 0 names way0.
// Ports: clk, rst (async active-high, clears all bits), updEn/updIndex/updValue
// (single write port), rdIndex/rdValue_c (combinational read port).
module cache_lru
   import cache_pkg::*;
(
   input  logic               clk,
   input  logic               rst,
   input  logic               updEn,
   input  logic [INDEX_W-1:0] updIndex,
   input  logic               updValue,
   input  logic [INDEX_W-1:0] rdIndex,
   output logic               rdValue_c
);

   logic [NUM_SETS-1:0] lruBits;

   // Bit table storage
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         lruBits <= '0;
      end else if (updEn) begin
         lruBits[updIndex] <= updValue;
      end
   end

   assign rdValue_c = lruBits[rdIndex];

endmodule

// File: rtl/cache_fill_ctrl.sv
// cache_fill_ctrl -- two-way cache miss fill controller.
// On a miss in IDLE it latches the address, picks a victim way, issues 8 word
// reads (FILL), writes each returned word into the victim way, then writes the
// meta entry for one cycle (META) and pulses fill_done.
// Ports: clk, rst (async active-high); miss_detected/miss_address/valid0/valid1
// (miss request); access_valid/hit0/hit1 (LRU hit update); memory_address/
// mem_read_en (read issue); memory_data/memory_data_valid (in-order returns);
// dataWE/metaWE/write0/write1/WordEnable/blockSelect/data/tag (cache writes);
// fsm_busy, fill_done (status).
// Build option: CACHE_FILL_CRITICAL_WORD_EN -- start the fill at the missed word.
module cache_fill_ctrl
   import cache_pkg::*;
(
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   miss_detected,
   input  logic [ADDR_W-1:0]      miss_address,
   input  logic                   valid0,
   input  logic                   valid1,
   input  logic                   access_valid,
   input  logic                   hit0,
   input  logic                   hit1,
   output logic [ADDR_W-1:0]      memory_address,
   output logic                   mem_read_en,
   input  logic [DATA_W-1:0]      memory_data,
   input  logic                   memory_data_valid,
   output logic                   dataWE,
   output logic                   metaWE,
   output logic                   write0,
   output logic                   write1,
   output logic [BLOCK_WORDS-1:0] WordEnable,
   output logic [NUM_SETS-1:0]    blockSelect,
   output logic [DATA_W-1:0]      data,
   output logic [META_W-1:0]      tag,
   output logic                   fsm_busy,
   output logic                   fill_done
);

   fillState_t         state, nextState;
   cacheAddr_t         missAddr_c;
   logic [TAG_W-1:0]   missTag;
   logic [INDEX_W-1:0] missIndex;
   logic               victimWay;
   logic               victimSel_c;
   logic [WORD_W-1:0]  startWord_c;
   logic [WORD_W-1:0]  reqWord, rxWord;
   logic [CNT_W-1:0]   reqCnt, rxCnt;
   logic               acceptRx_c;
   logic               lruRd_c;
   logic               lruWe_c;
   logic [INDEX_W-1:0] lruWrIndex_c;
   logic               lruWrValue_c;
   logic               unusedOffset;

   assign missAddr_c = cacheAddr_t'(miss_address);

`ifdef CACHE_FILL_CRITICAL_WORD_EN
   assign startWord_c = missAddr_c.offset[OFFSET_W-1:1];
`else
   assign startWord_c = '0;
`endif
   // Byte-offset bits are not needed in every build
   assign unusedOffset = ^missAddr_c.offset;

   // First invalid way wins (way0 on a tie); with both ways valid the LRU bit decides
   assign victimSel_c = !valid0 ? 1'b0 :
                        !valid1 ? 1'b1 : lruRd_c;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next state and cache/memory interface outputs
   always_comb begin
      nextState      = state;
      mem_read_en    = 1'b0;
      memory_address = '0;
      dataWE         = 1'b0;
      metaWE         = 1'b0;
      write0         = 1'b0;
      write1         = 1'b0;
      WordEnable     = '0;
      blockSelect    = '0;
      data           = '0;
      tag            = '0;
      fsm_busy       = 1'b0;
      fill_done      = 1'b0;
      acceptRx_c     = 1'b0;
      case (state)
         IDLE: begin
            if (miss_detected) begin
               nextState = FILL;
            end
         end
         FILL: begin
            fsm_busy    = 1'b1;
            blockSelect = NUM_SETS'(1) << missIndex;
            if (reqCnt != CNT_W'(BLOCK_WORDS)) begin
               mem_read_en    = 1'b1;
               memory_address = {missTag, missIndex, reqWord, 1'b0};
            end
            // Returns beyond the 8th are dropped; the 8th moves on to META
            if (memory_data_valid && (rxCnt != CNT_W'(BLOCK_WORDS))) begin
               acceptRx_c = 1'b1;
               dataWE     = 1'b1;
               data       = memory_data;
               WordEnable = BLOCK_WORDS'(1) << rxWord;
               write0     = ~victimWay;
               write1     = victimWay;
               if (rxCnt == CNT_W'(BLOCK_WORDS - 1)) begin
                  nextState = META;
               end
            end
         end
         META: begin
            fsm_busy                 = 1'b1;
            blockSelect              = NUM_SETS'(1) << missIndex;
            metaWE                   = 1'b1;
            tag[META_VALID_BIT]      = 1'b1;
            tag[TAG_W-1:0]           = missTag;
            fill_done                = 1'b1;
            nextState                = IDLE;
         end
         default: begin
            nextState = IDLE;
         end
      endcase
   end

   // Miss capture and request/receive word counters
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         missTag   <= '0;
         missIndex <= '0;
         victimWay <= 1'b0;
         reqWord   <= '0;
         rxWord    <= '0;
         reqCnt    <= '0;
         rxCnt     <= '0;
      end else if (state == IDLE) begin
         if (miss_detected) begin
            missTag   <= missAddr_c.tag;
            missIndex <= missAddr_c.index;
            victimWay <= victimSel_c;
            reqWord   <= startWord_c;
            rxWord    <= startWord_c;
            reqCnt    <= '0;
            rxCnt     <= '0;
         end
      end else begin
         if (mem_read_en) begin
            reqWord <= reqWord + WORD_W'(1);
            reqCnt  <= reqCnt + CNT_W'(1);
         end
         if (acceptRx_c) begin
            rxWord <= rxWord + WORD_W'(1);
            rxCnt  <= rxCnt + CNT_W'(1);
         end
      end
   end

   // LRU update: the META write (filled way becomes MRU) owns the single port
   // whenever it occurs; a hit update in that cycle is dropped.
   always_comb begin
      lruWe_c      = 1'b0;
      lruWrIndex_c = missIndex;
      lruWrValue_c = ~victimWay;
      if (state == META) begin
         lruWe_c = 1'b1;
      end else if (access_valid && (hit0 || hit1)) begin
         lruWe_c      = 1'b1;
         lruWrIndex_c = missAddr_c.index;
         lruWrValue_c = hit0;
      end
   end

   cache_lru uLru (
      .clk      (clk),
      .rst      (rst),
      .updEn    (lruWe_c),
      .updIndex (lruWrIndex_c),
      .updValue (lruWrValue_c),
      .rdIndex  (missAddr_c.index),
      .rdValue_c(lruRd_c)
   );

endmodule

// File: tb/tb_cache_fill_ctrl.sv
// tb_cache_fill_ctrl -- self-checking bench for cache_fill_ctrl.
// A table of miss records is applied through one fill driver; issued reads push
// expected cache writes to a scoreboard that is popped on each dataWE.
// Build option: CACHE_FILL_CRITICAL_WORD_EN changes the expected word order.
module tb_cache_fill_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        miss_detected;
   logic [15:0] miss_address;
   logic        valid0, valid1;
   logic        access_valid, hit0, hit1;
   logic [15:0] memory_address;
   logic        mem_read_en;
   logic [15:0] memory_data;
   logic        memory_data_valid;
   logic        dataWE, metaWE, write0, write1;
   logic [7:0]  WordEnable;
   logic [63:0] blockSelect;
   logic [15:0] data;
   logic [7:0]  tag;
   logic        fsm_busy, fill_done;

   int nTests = 0;
   int nFail  = 0;

   typedef struct {
      logic [15:0] addr;
      logic        v0;
      logic        v1;
      int          lat;
      int          gap;
      logic        preHit0;
      logic        preHit1;
      logic        expWay;
      logic [7:0]  expTag;
   } vec_t;

   typedef struct {
      logic [15:0] data;
      logic [7:0]  we;
   } sb_t;

   typedef struct {
      logic [15:0] data;
      int          cyc;
   } ret_t;

   sb_t  sbQ[$];
   ret_t retQ[$];
   vec_t vecs[6];

`ifdef CACHE_FILL_CRITICAL_WORD_EN
   localparam bit CRIT = 1'b1;
`else
   localparam bit CRIT = 1'b0;
`endif

   always #5 clk = ~clk;

   cache_fill_ctrl dut (
      .clk              (clk),
      .rst              (rst),
      .miss_detected    (miss_detected),
      .miss_address     (miss_address),
      .valid0           (valid0),
      .valid1           (valid1),
      .access_valid     (access_valid),
      .hit0             (hit0),
      .hit1             (hit1),
      .memory_address   (memory_address),
      .mem_read_en      (mem_read_en),
      .memory_data      (memory_data),
      .memory_data_valid(memory_data_valid),
      .dataWE           (dataWE),
      .metaWE           (metaWE),
      .write0           (write0),
      .write1           (write1),
      .WordEnable       (WordEnable),
      .blockSelect      (blockSelect),
      .data             (data),
      .tag              (tag),
      .fsm_busy         (fsm_busy),
      .fill_done        (fill_done)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      nTests++;
      if (act !== exp) begin
         nFail++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic logic [15:0] memData(input logic [15:0] a);
      return {a[7:0], a[15:8]} ^ 16'h3C3C;
   endfunction

   task automatic checkQuiet(input string name);
      check({name, ".rd"},   64'(mem_read_en), 64'd0);
      check({name, ".addr"}, 64'(memory_address), 64'd0);
      check({name, ".dwe"},  64'(dataWE), 64'd0);
      check({name, ".mwe"},  64'(metaWE), 64'd0);
      check({name, ".way"},  64'({write0, write1}), 64'd0);
      check({name, ".wen"},  64'(WordEnable), 64'd0);
      check({name, ".bsel"}, 64'(blockSelect), 64'd0);
      check({name, ".busy"}, 64'({fsm_busy, fill_done}), 64'd0);
   endtask

   // Drives one miss and its memory returns; abortAfter >= 0 resets the DUT
   // right after that many returns have been written.
   task automatic runFill(input logic [15:0] addr, input logic v0, input logic v1,
                          input int lat, input int gap, input logic expWay,
                          input logic [7:0] expTag, input logic holdMiss,
                          input logic spurious, input int abortAfter);
      int          cyc, nIss, nRet, nWe, lastRet;
      bit          done, realRet, expMeta;
      logic [2:0]  w0, w;
      logic [15:0] a;
      sb_t         s;
      ret_t        r;
      sbQ.delete();
      retQ.delete();
      w0 = CRIT ? addr[3:1] : 3'd0;
      @(negedge clk);
      miss_address  = addr;
      valid0        = v0;
      valid1        = v1;
      miss_detected = 1'b1;
      @(negedge clk);
      if (!holdMiss) miss_detected = 1'b0;
      cyc = 0; nIss = 0; nRet = 0; nWe = 0; lastRet = -100; done = 1'b0;
      while (!done && cyc < 300) begin
         memory_data_valid = 1'b0;
         memory_data       = 16'h0000;
         #1;
         check("busy", 64'(fsm_busy), 64'd1);
         if (mem_read_en) begin
            w = w0 + 3'(nIss);
            a = {addr[15:4], w, 1'b0};
            check("rdAddr", 64'(memory_address), 64'(a));
            check("rdCount", 64'(nIss < 8), 64'd1);
            nIss++;
            s.data = memData(a);
            s.we   = 8'd1 << w;
            sbQ.push_back(s);
            r.data = memData(a);
            r.cyc  = cyc;
            retQ.push_back(r);
         end
         realRet = 1'b0;
         if (retQ.size() > 0 && cyc >= retQ[0].cyc + lat && cyc > lastRet + gap) begin
            r = retQ.pop_front();
            memory_data_valid = 1'b1;
            memory_data       = r.data;
            realRet           = 1'b1;
            lastRet           = cyc;
            nRet++;
         end else if (spurious && nIss == 8 && retQ.size() == 0) begin
            memory_data_valid = 1'b1;
            memory_data       = 16'hDEAD;
         end
         #1;
         check("dataWE", 64'(dataWE), 64'(realRet));
         if (dataWE && realRet && sbQ.size() > 0) begin
            s = sbQ.pop_front();
            check("wrData", 64'(data), 64'(s.data));
            check("wordEn", 64'(WordEnable), 64'(s.we));
            check("way", 64'({write1, write0}), 64'({expWay, ~expWay}));
            check("bsel", blockSelect, 64'd1 << addr[9:4]);
            nWe++;
         end
         expMeta = (nRet == 8) && (cyc == lastRet + 1);
         check("metaWE", 64'(metaWE), 64'(expMeta));
         if (metaWE && expMeta) begin
            check("metaTag", 64'(tag), 64'(expTag));
            check("fillDone", 64'(fill_done), 64'd1);
            check("metaBsel", blockSelect, 64'd1 << addr[9:4]);
            check("nWe", 64'(nWe), 64'd8);
            done = 1'b1;
         end
         if (abortAfter >= 0 && nWe == abortAfter) begin
            @(negedge clk);
            rst               = 1'b1;
            memory_data_valid = 1'b0;
            miss_detected     = 1'b0;
            #1;
            checkQuiet("abort");
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 4; i++) begin
               #1;
               check("abortNoMeta", 64'({metaWE, fsm_busy}), 64'd0);
               @(negedge clk);
            end
            return;
         end
         @(negedge clk);
         cyc++;
      end
      miss_detected     = 1'b0;
      memory_data_valid = 1'b0;
      if (!done) check("fillTimeout", 64'(done), 64'd1);
      check("nIss", 64'(nIss), 64'd8);
   endtask

   task automatic preHit(input logic [15:0] addr, input logic h0, input logic h1);
      @(negedge clk);
      miss_address = addr;
      access_valid = 1'b1;
      hit0         = h0;
      hit1         = h1;
      @(negedge clk);
      access_valid = 1'b0;
      hit0         = 1'b0;
      hit1         = 1'b0;
   endtask

   initial begin
      rst = 1'b1;
      miss_detected = 1'b0; miss_address = '0; valid0 = 1'b0; valid1 = 1'b0;
      access_valid = 1'b0; hit0 = 1'b0; hit1 = 1'b0;
      memory_data = '0; memory_data_valid = 1'b0;

      //            addr      v0 v1 lat gap h0 h1 way tag
      vecs[0] = '{16'h1234, 0, 0, 1, 0, 0, 0, 0, 8'h84};
      vecs[1] = '{16'h1234, 1, 1, 2, 0, 1, 0, 1, 8'h84};
      vecs[2] = '{16'h1234, 1, 1, 1, 0, 0, 0, 0, 8'h84};
      vecs[3] = '{16'h5678, 1, 0, 4, 1, 0, 0, 1, 8'h95};
      vecs[4] = '{16'h000C, 0, 1, 0, 0, 0, 0, 0, 8'h80};
      vecs[5] = '{16'hFFFE, 1, 1, 2, 2, 1, 0, 1, 8'hBF};

      repeat (2) @(negedge clk);
      #1;
      checkQuiet("reset");
      rst = 1'b0;

      foreach (vecs[i]) begin
         if (vecs[i].preHit0 || vecs[i].preHit1)
            preHit(vecs[i].addr, vecs[i].preHit0, vecs[i].preHit1);
         runFill(vecs[i].addr, vecs[i].v0, vecs[i].v1, vecs[i].lat, vecs[i].gap,
                 vecs[i].expWay, vecs[i].expTag, 1'b0, 1'b0, -1);
      end

      // Spurious returns while idle must not write anything
      @(negedge clk);
      memory_data_valid = 1'b1;
      memory_data       = 16'hBEEF;
      for (int i = 0; i < 3; i++) begin
         #1;
         check("idleSpur", 64'({dataWE, fsm_busy, mem_read_en}), 64'd0);
         @(negedge clk);
      end
      memory_data_valid = 1'b0;

      // Miss held through the fill, spurious valid in META: single fill only
      runFill(16'h0ABC, 1, 0, 3, 0, 1'b1, 8'h82, 1'b1, 1'b1, -1);
      for (int i = 0; i < 4; i++) begin
         #1;
         check("afterHold", 64'({fsm_busy, mem_read_en, dataWE}), 64'd0);
         @(negedge clk);
      end

      // Reset after the 3rd return, then a clean full fill (LRU cleared -> way0)
      runFill(16'h2468, 0, 0, 1, 0, 1'b0, 8'h89, 1'b0, 1'b0, 3);
      runFill(16'h2468, 1, 1, 1, 0, 1'b0, 8'h89, 1'b0, 1'b0, -1);

      $display("[TB] %0d tests run, %0d failed", nTests, nFail);
      $finish;
   end

endmodule

// File: doc/cache_fill_ctrl.md
CACHE_FILL_CTRL -- requirements
Module: cache_fill_ctrl

Interface
REQ-001 The block SHALL expose: clk  in  1  single clock; all state on rising edge.
REQ-002 The block SHALL expose: rst  in  1  asynchronous, active-high reset.
REQ-003 The block SHALL expose: miss_detected  in  1  miss request, sampled in IDLE only.
REQ-004 The block SHALL expose: miss_address  in  16  byte address of the miss, with tag[15:10], index[9:4] and offset[3:0].
REQ-005 The block SHALL expose: valid0, valid1  in  1 each  valid bits (meta bit7) of both ways at the miss index.
REQ-006 The block SHALL expose: access_valid, hit0, hit1  in  1 each  hit reporting used for LRU update.
REQ-007 The block SHALL expose: memory_address  out  16  word-aligned read address.
REQ-008 The block SHALL expose: mem_read_en  out  1  one read issued per asserted cycle.
REQ-009 The block SHALL expose: memory_data  in  16 and memory_data_valid  in  1  read returns, in issue order.
REQ-010 The block SHALL expose: dataWE, metaWE  out  1 each  cache data and meta write enables.
REQ-011 The block SHALL expose: write0, write1  out  1 each  one-hot victim-way select.
REQ-012 The block SHALL expose: WordEnable  out  8  one-hot word select.
REQ-013 The block SHALL expose: blockSelect  out  64  one-hot set select.
REQ-014 The block SHALL expose: data  out  16  cache write data.
REQ-015 The block SHALL expose: tag  out  8  meta write value.
REQ-016 The block SHALL expose: fsm_busy  out  1  fill in progress, and fill_done  out  1  single-cycle completion pulse.

Function
REQ-017 The FSM SHALL have the states IDLE, FILL and META, and it SHALL be in IDLE when out of reset.
REQ-018 When miss_detected is high in IDLE, the block SHALL latch miss_address and choose a victim, then move to FILL on the next edge.
REQ-019 Victim selection: the block SHALL pick the first invalid way, taking way0 when both ways are invalid; when both are valid it SHALL pick the way given by lru[index].
REQ-020 In FILL, the block SHALL assert mem_read_en for exactly 8 consecutive cycles, starting in the first FILL cycle.
REQ-021 memory_address SHALL be {tag, index, word[2:0], 1'b0}, using a 3-bit request counter that wraps modulo 8.
REQ-022 Each memory_data_valid in FILL SHALL drive dataWE=1, data=memory_data (combinational pass-through), WordEnable=onehot(receive counter) and the victim write0/write1 in the same cycle.
REQ-023 fsm_busy SHALL be 1 in FILL and META, and 0 in IDLE.
REQ-024 After the 8th valid return, the block SHALL enter META; META lasts one cycle with metaWE=1, tag={1'b1, 1'b0, latched tag[5:0]} and fill_done=1, then the block returns to IDLE.
REQ-025 blockSelect SHALL be onehot(latched index) in FILL and META, and all-zero in IDLE.
REQ-026 dataWE, metaWE, write0, write1 and WordEnable SHALL be 0 whenever no write occurs.
REQ-027 LRU update: access_valid&hit0 SHALL set lru[index]=1, and access_valid&hit1 SHALL set lru[index]=0, where index is miss_address[9:4].
REQ-028 On a META cycle the LRU bit SHALL be set to mark the filled way as MRU.
REQ-029 When a META update and a hit update target the same set in the same cycle, the META update SHALL win.
REQ-030 Ignored events: miss_detected outside IDLE SHALL be ignored; memory_data_valid in IDLE or META SHALL be ignored; any valid beyond the 8th SHALL be ignored.
REQ-031 Returns SHALL be accepted at any latency at or after issue, including latency 0 and gaps between returns.

Reset
REQ-032 On rst, the block SHALL go immediately to IDLE, clear both counters, clear all 64 LRU bits (victim = way0), and drive all outputs to 0.
REQ-033 A reset mid-fill SHALL abandon the fill, and no metaWE SHALL be issued for it.

Configuration
REQ-034 With CACHE_FILL_CRITICAL_WORD_EN defined, both counters SHALL start at miss_address[3:1] and wrap 7->0, so that the missed word is fetched and written first.
REQ-035 Without CACHE_FILL_CRITICAL_WORD_EN, both counters SHALL start at 0.

Structure
REQ-036 Package cache_pkg SHALL hold NUM_SETS=64, BLOCK_WORDS=8, the tag/index/offset field widths, the meta bit positions and the state enum.
REQ-037 The LRU bit table (64 bits, one update port, one read port) SHALL be a sub-module named cache_lru.

Verification
REQ-038 The bench SHALL check: reset, then miss at 0x1234 with valid0=valid1=0 -> reads 0x1230..0x123E; writes use write0, blockSelect bit 35, then metaWE with tag=0x84 and a fill_done pulse.
REQ-039 The bench SHALL check: valid0=valid1=1 with lru[35]=0, then hit0 at index 35, then a miss at index 35 -> write1 is selected; after META, lru[35]=0.
REQ-040 The bench SHALL check: memory latency 4 with one-cycle gaps between returns -> exactly 8 dataWE pulses in order, and metaWE one cycle after the last return.
REQ-041 The bench SHALL check: with CACHE_FILL_CRITICAL_WORD_EN and a miss at 0x000C -> address order 0x000C, 0x000E, 0x0000 ... 0x000A, and WordEnable first value 0x40.
REQ-042 The bench SHALL check: rst asserted after the 3rd return -> outputs go to 0 at once, no metaWE is issued, and a following miss restarts from a full 8-word fill.
REQ-043 The bench SHALL check: miss_detected held high during a fill, plus spurious memory_data_valid in IDLE -> no second fill starts and no writes occur.
